// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the RV32 pipeline.
//
// The stage holds the PC and issues word fetches to a synchronous instruction
// memory. Read data returns one cycle after the request. The returned word is
// registered into the IF/ID outputs. The branch unit can redirect the PC
// (miss_predict/target) and insert bubbles (flush). The hazard unit can freeze
// the stage (stall). A word that is already in flight when a stall begins is
// parked in a hold register, so it is neither lost nor fetched twice.
//
// Parameters:
//   RESET_PC    - first fetch address after reset
//   NOP_INSTR   - instruction shown on if_id_instr whenever IF/ID is invalid
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   stall               - hazard unit freeze request
//   miss_predict,target - branch unit redirect (target low bits are ignored)
//   flush               - branch unit bubble request (IF/ID + in-flight fetch)
//   imem_req, imem_addr - fetch request and word address (imem_addr == PC)
//   imem_rdata          - instruction, valid the cycle after an accepted request
//   if_id_valid/pc/instr- IF/ID pipeline register outputs
//   fetch_count         - number of valid instructions delivered into IF/ID
//
// Optional feature macro: IF_STAGE_MISALIGN_TRAP_EN
//   When defined, adds output misalign_err. It is a sticky flag that is set by a
//   redirect to a target that is not word aligned, and cleared only by reset.

module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        miss_predict,
  input  logic [31:0] target,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] fetch_count
`ifdef IF_STAGE_MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [31:0] pc_q;
  logic        f2_valid;
  logic [31:0] f2_pc;
  logic [31:0] hold_data;
  logic        hold_valid;

  logic        advance;
  logic        enter_hold;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_data;

  // Redirect targets are forced onto a word boundary.
  assign redirect_pc = target & 32'hFFFF_FFFC;
  assign imem_addr   = pc_q;

  // Once a word has been parked, it takes precedence over the memory port. The
  // memory output is not meaningful after a cycle with no request.
  assign fetch_data  = hold_valid ? hold_data : imem_rdata;

  // Register the FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Compute the next state and the advance/request controls.
  // The stage advances in RUN or HOLD whenever it is not stalled.
  // A stall that begins while a fetch is in flight moves the FSM to HOLD.
  // A redirect or flush empties the fetch pipe, so the FSM always goes back to RUN.
  always_comb begin
    state_d    = state_q;
    advance    = 1'b0;
    enter_hold = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = RUN;
      end
      RUN: begin
        advance = !stall;
        if (stall && f2_valid) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        advance = !stall;
        if (!stall) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (miss_predict || flush) begin
      state_d = RUN;
    end
    enter_hold = (state_q == RUN) && (state_d == HOLD);
    imem_req   = advance;
  end

  // Update the PC, the in-flight tag, the hold register and the IF/ID register.
  // A redirect overrides a stall for the PC and for the in-flight state.
  // A flush always writes a bubble into IF/ID, even while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      f2_valid    <= 1'b0;
      f2_pc       <= 32'h0;
      hold_data   <= 32'h0;
      hold_valid  <= 1'b0;
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'h0;
      if_id_instr <= NOP_INSTR;
      fetch_count <= 32'h0;
    end else begin
      if (miss_predict) begin
        pc_q <= redirect_pc;
      end else if (advance) begin
        pc_q <= pc_q + 32'd4;
      end

      if (miss_predict || flush) begin
        f2_valid <= 1'b0;
      end else if (advance) begin
        f2_valid <= 1'b1;
        f2_pc    <= pc_q;
      end

      if (miss_predict || flush) begin
        hold_valid <= 1'b0;
      end else if (enter_hold) begin
        hold_data  <= imem_rdata;
        hold_valid <= 1'b1;
      end else if (advance) begin
        hold_valid <= 1'b0;
      end

      if (flush) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end else if (advance) begin
        if_id_valid <= f2_valid;
        if_id_pc    <= f2_pc;
        if_id_instr <= f2_valid ? fetch_data : NOP_INSTR;
        if (f2_valid) begin
          fetch_count <= fetch_count + 32'd1;
        end
      end
    end
  end

`ifdef IF_STAGE_MISALIGN_TRAP_EN
  // Hold the misalignment flag once it is set. Only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else if (miss_predict && (target[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the RV32 pipeline, directly upstream of the IF/ID consumers and downstream of the EX-stage branch unit. Holds the PC and issues word fetches to a synchronous instruction memory. Registers the returned instruction into the IF/ID outputs. Applies the branch unit's `miss_predict`/`target` redirect and `flush` bubble insertion, and honours a hazard-unit stall without losing in-flight fetch data.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013: instruction presented on `if_id_instr` when the stage is invalid or in reset (`addi x0,x0,0`).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `stall` input 1: hazard unit; freezes the PC and IF/ID outputs.
- `miss_predict` input 1: branch unit; redirects the PC to `target`.
- `target` input 32: branch unit redirect address.
- `flush` input 1: branch unit; invalidates IF/ID and in-flight fetches.
- `imem_req` output 1: fetch request valid this cycle.
- `imem_addr` output 32: fetch address; equals the PC register.
- `imem_rdata` input 32: instruction, valid the cycle after an accepted `imem_req`.
- `if_id_valid` output 1: IF/ID holds a real instruction.
- `if_id_pc` output 32: PC of `if_id_instr`.
- `if_id_instr` output 32: fetched instruction.
- `fetch_count` output 32: number of instructions delivered valid into IF/ID; wraps at 2^32.

## Operation
- FSM states: IDLE, RUN, HOLD.
  - IDLE: entered on reset; `imem_req`=0. Moves to RUN on the first edge after `rst_n` rises.
  - RUN: `imem_req`=1 unless `stall`.
  - HOLD: entered from RUN when `stall`=1 while a fetch is in flight. Captures `imem_rdata` once into a hold register.
  - HOLD returns to RUN when `stall`=0; IF/ID then loads the hold register instead of `imem_rdata`.
- Internal state: PC register `pc_q`; in-flight tag `f2_valid`/`f2_pc`; hold register plus `hold_valid`.
- RUN, no stall, no redirect, per edge:
  - `pc_q` <= `pc_q`+4, modulo 2^32, wraps silently.
  - `f2_pc` <= `pc_q`; `f2_valid` <= 1.
  - IF/ID <= {`f2_valid`, `f2_pc`, data}, where data is the hold register if `hold_valid`, else `imem_rdata`.
  - `fetch_count` increments when the loaded valid bit is 1.
- Stall (no redirect): `pc_q`, `f2_*` and IF/ID hold; `imem_req`=0; `fetch_count` holds.
- Redirect (`miss_predict`=1) takes priority over `stall`:
  - `pc_q` <= {`target`[31:2], 2'b00}.
  - `f2_valid` <= 0; `hold_valid` <= 0; FSM -> RUN.
- Flush (`flush`=1): `if_id_valid` <= 0 and `if_id_instr` <= `NOP_INSTR` on that edge, regardless of `stall`.
- `flush` and `miss_predict` are level signals. Each cycle either is high repeats its action, so a multi-cycle flush yields multiple bubbles and re-loads `target`. No edge detection.
- `flush` without `miss_predict`: invalidate IF/ID and `f2_valid`; the PC continues.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), and any in-flight fetch is dropped.
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `if_id_valid`=0, `if_id_pc`=0, `if_id_instr`=`NOP_INSTR`.
  - `fetch_count`=0; FSM=IDLE; `f2_valid`=0; `hold_valid`=0.

## Timing
- Fetch of address A issued in cycle N (`imem_req`=1, `imem_addr`=A). Instruction appears on IF/ID outputs in cycle N+2, giving 2-cycle fetch latency.
- Redirect sampled at the edge ending cycle N: `imem_addr`=`target` in cycle N+1, and the target instruction reaches IF/ID in cycle N+3. This gives 2 bubble cycles when `flush` accompanies it.
- Stall sampled high at the edge ending cycle N: IF/ID frozen from cycle N+1. The first new IF/ID load happens at the edge after `stall` falls.
- Steady-state throughput is 1 instruction/cycle; no bubbles are inserted by the stage itself except after reset (2 cycles) and redirect.

## Configuration
- `IF_STAGE_MISALIGN_TRAP_EN`
  - Defined: adds output `misalign_err` (1 bit, reset 0). It is set on a redirect edge with `target[1:0]` != 0 and stays set until reset. The misaligned redirect is still taken with low bits cleared.
  - Undefined: the port is absent and low bits of `target` are cleared silently.

## Test plan
- Reset release, `RESET_PC`=0, no stall -> `imem_addr` 0,4,8,… from cycle 1. `if_id_valid`=1 with `if_id_pc`=0 from cycle 3; `fetch_count`=1 then increments by 1/cycle.
- Redirect: `miss_predict`=`flush`=1 for one cycle with `target`=0x100 while fetching 0x20 -> next `imem_addr`=0x100. `if_id_valid`=0 for 2 cycles, then `if_id_pc`=0x100.
- Stall 3 cycles mid-stream -> `imem_req`=0 and IF/ID unchanged during the stall. The instruction in flight at stall onset appears next with no loss or duplication, and `fetch_count` does not advance.
- Redirect during stall: `stall`=1 and `miss_predict`=1 with `target`=0x200 -> hold data discarded. `imem_addr`=0x200 next cycle; no stale instruction reaches IF/ID.
- `flush` held 2 cycles with `miss_predict` -> 2 consecutive bubble loads and `target` re-issued each cycle; `if_id_instr`=0x0000_0013 while invalid.
- Macro defined, `target`=0x102 -> `imem_addr`=0x100 and `misalign_err`=1 until `rst_n` is asserted low.
